// File: rtl/ub_access_controller.sv
// Unified buffer access sequencer: round-robin write arbiter for host and
// accumulator, plus a stallable burst read engine feeding the systolic array.
module ub_access_controller #(
   parameter int ADDR_W = 12,
   parameter int LANES  = 32,
   parameter int DATA_W = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           host_wr_req_i,
   input  logic [ADDR_W-1:0]              host_wr_addr_i,
   input  logic [LANES-1:0][DATA_W-1:0]   host_wr_data_i,
   output logic                           host_wr_gnt_o,
   input  logic                           acc_wr_req_i,
   input  logic [ADDR_W-1:0]              acc_wr_addr_i,
   input  logic [LANES-1:0][DATA_W-1:0]   acc_wr_data_i,
   output logic                           acc_wr_gnt_o,
   input  logic                           rd_start_i,
   input  logic [ADDR_W-1:0]              rd_base_i,
   input  logic [ADDR_W-1:0]              rd_count_i,
   input  logic                           rd_stall_i,
   output logic                           rd_busy_o,
   output logic                           rd_valid_o,
   output logic                           rd_done_o,
   output logic                           ub_write_o,
   output logic [ADDR_W-1:0]              ub_addr_wr_o,
   output logic [LANES-1:0][DATA_W-1:0]   ub_data_o,
   output logic                           ub_read_o,
   output logic [ADDR_W-1:0]              ub_addr_rd_o
);

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DRAIN
   } rd_state_t;

   logic              prio_acc_q;
   rd_state_t         state_q;
   logic [ADDR_W-1:0] rem_q;

   // priority bit set means the accumulator wins a tie
   assign host_wr_gnt_o = rst_ni & host_wr_req_i
                        & (~acc_wr_req_i | ~prio_acc_q);
   assign acc_wr_gnt_o  = rst_ni & acc_wr_req_i
                        & (~host_wr_req_i | prio_acc_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_acc_q   <= 1'b0;
         ub_write_o   <= 1'b0;
         ub_addr_wr_o <= '0;
         ub_data_o    <= '0;
      end else begin
         ub_write_o <= host_wr_gnt_o | acc_wr_gnt_o;
         unique case (1'b1)
            host_wr_gnt_o: begin
               ub_addr_wr_o <= host_wr_addr_i;
               ub_data_o    <= host_wr_data_i;
               prio_acc_q   <= 1'b1;
            end
            acc_wr_gnt_o: begin
               ub_addr_wr_o <= acc_wr_addr_i;
               ub_data_o    <= acc_wr_data_i;
               prio_acc_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign rd_busy_o = (state_q != IDLE);

   // rem_q counts addresses still to issue after the one on ub_addr_rd_o
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         rem_q        <= '0;
         ub_read_o    <= 1'b0;
         ub_addr_rd_o <= '0;
         rd_valid_o   <= 1'b0;
         rd_done_o    <= 1'b0;
      end else begin
         rd_valid_o <= ub_read_o;
         rd_done_o  <= 1'b0;
         ub_read_o  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (rd_start_i) begin
                  state_q      <= BURST;
                  rem_q        <= rd_count_i;
                  ub_read_o    <= 1'b1;
                  ub_addr_rd_o <= rd_base_i;
               end
            end
            BURST: begin
               if (rem_q == '0) begin
                  state_q   <= DRAIN;
                  rd_done_o <= 1'b1;
               end else if (!rd_stall_i) begin
                  ub_read_o    <= 1'b1;
                  ub_addr_rd_o <= ub_addr_rd_o + ADDR_W'(1);
                  rem_q        <= rem_q - ADDR_W'(1);
               end
            end
            DRAIN: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ub_access_controller.sv
// Bench for ub_access_controller: arbiter vector table, burst sequences,
// and queue scoreboards for the buffer write and read ports.
module tb_ub_access_controller;

   localparam int AW = 12;
   localparam int L  = 32;
   localparam int DW = 16;

   typedef logic [L-1:0][DW-1:0] word_t;

   typedef struct {
      bit          h;
      bit          a;
      logic [AW-1:0] ha;
      logic [AW-1:0] aa;
      logic [15:0] hd;
      logic [15:0] ad;
      bit          eh;
      bit          ea;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      word_t         data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          host_req, acc_req;
   logic [AW-1:0] host_addr, acc_addr;
   word_t         host_data, acc_data;
   logic          host_gnt, acc_gnt;
   logic          rd_start, rd_stall;
   logic [AW-1:0] rd_base, rd_count;
   logic          rd_busy, rd_valid, rd_done;
   logic          ub_write, ub_read;
   logic [AW-1:0] ub_addr_wr, ub_addr_rd;
   word_t         ub_data;

   int checks = 0;
   int errors = 0;
   int vcnt, dcnt, gaps;
   wr_t           wr_q[$];
   logic [AW-1:0] rd_q[$];
   vec_t          v[10];

   ub_access_controller #(.ADDR_W(AW), .LANES(L), .DATA_W(DW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .host_wr_req_i (host_req),
      .host_wr_addr_i(host_addr),
      .host_wr_data_i(host_data),
      .host_wr_gnt_o (host_gnt),
      .acc_wr_req_i  (acc_req),
      .acc_wr_addr_i (acc_addr),
      .acc_wr_data_i (acc_data),
      .acc_wr_gnt_o  (acc_gnt),
      .rd_start_i    (rd_start),
      .rd_base_i     (rd_base),
      .rd_count_i    (rd_count),
      .rd_stall_i    (rd_stall),
      .rd_busy_o     (rd_busy),
      .rd_valid_o    (rd_valid),
      .rd_done_o     (rd_done),
      .ub_write_o    (ub_write),
      .ub_addr_wr_o  (ub_addr_wr),
      .ub_data_o     (ub_data),
      .ub_read_o     (ub_read),
      .ub_addr_rd_o  (ub_addr_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [511:0] act,
                      input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic word_t mkword(input logic [15:0] l0);
      word_t w;
      for (int i = 0; i < L; i++) w[i] = l0 ^ (16'(i) * 16'h0101);
      return w;
   endfunction

   always @(negedge clk) begin : mon
      wr_t e;
      logic [AW-1:0] ea;
      if (rst_n) begin
         if (ub_write) begin
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected actual=%0h required=none",
                        ub_addr_wr);
            end else begin
               e = wr_q.pop_front();
               chk("wr_addr", 512'(ub_addr_wr), 512'(e.addr));
               chk("wr_data", ub_data, e.data);
            end
         end
         if (ub_read) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected actual=%0h required=none",
                        ub_addr_rd);
            end else begin
               ea = rd_q.pop_front();
               chk("rd_addr", 512'(ub_addr_rd), 512'(ea));
            end
         end
         if (rd_valid) vcnt++;
         if (rd_done) begin
            dcnt++;
            chk("done_with_valid", 512'(rd_valid), 512'(1));
         end
         if (rd_busy && !ub_read && !rd_done) gaps++;
      end
   end

   task automatic burst(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                        input int st_from, input int st_len, input bit poke);
      int n;
      logic [3:0] exp;
      logic [AW-1:0] held;
      n = int'(cnt) + 1;
      held = base + AW'(st_from - 1);
      @(posedge clk);
      #1;
      vcnt = 0;
      dcnt = 0;
      gaps = 0;
      rd_start = 1'b1;
      rd_base  = base;
      rd_count = cnt;
      for (int k = 0; k < n; k++) rd_q.push_back(base + AW'(k));
      for (int j = 1; j <= n + 2 + st_len; j++) begin
         @(posedge clk);
         #1;
         rd_start = poke && (j == 2);
         rd_base  = 12'h7AB;
         rd_stall = (j >= st_from) && (j < st_from + st_len);
         @(negedge clk);
         if (st_len == 0) begin
            exp = {j <= n + 1, j <= n, (j >= 2) && (j <= n + 1), j == n + 1};
            chk($sformatf("burst_t%0d", j),
                512'({rd_busy, ub_read, rd_valid, rd_done}), 512'(exp));
         end else if (j > st_from && j <= st_from + st_len) begin
            chk("stall_gap", 512'({ub_read, ub_addr_rd}),
                512'({1'b0, held}));
         end
      end
      rd_stall = 1'b0;
      chk("valid_count", 512'(vcnt), 512'(n));
      chk("done_count", 512'(dcnt), 512'(1));
      chk("gap_count", 512'(gaps), 512'(st_len));
      chk("rd_q_empty", 512'(rd_q.size()), 512'(0));
      chk("busy_end", 512'(rd_busy), 512'(0));
   endtask

   initial begin
      v[0] = '{1, 1, 12'h001, 12'h801, 16'h1111, 16'h2222, 1, 0};
      v[1] = '{1, 1, 12'h002, 12'h802, 16'h1112, 16'h2223, 0, 1};
      v[2] = '{1, 1, 12'h003, 12'h803, 16'h1113, 16'h2224, 1, 0};
      v[3] = '{0, 0, 12'h004, 12'h804, 16'h1114, 16'h2225, 0, 0};
      v[4] = '{1, 0, 12'h005, 12'h805, 16'h1115, 16'h2226, 1, 0};
      v[5] = '{1, 1, 12'h006, 12'h806, 16'h1116, 16'h2227, 0, 1};
      v[6] = '{0, 1, 12'h007, 12'h010, 16'h1117, 16'h1234, 0, 1};
      v[7] = '{1, 1, 12'hFFF, 12'h808, 16'hABCD, 16'h2229, 1, 0};
      v[8] = '{0, 1, 12'h009, 12'h809, 16'h1119, 16'h222A, 0, 1};
      v[9] = '{1, 1, 12'h00A, 12'h80A, 16'h5A5A, 16'h222B, 1, 0};

      rst_n     = 1'b0;
      host_req  = 1'b1;
      acc_req   = 1'b1;
      host_addr = 12'h0AA;
      acc_addr  = 12'h0BB;
      host_data = mkword(16'hDEAD);
      acc_data  = mkword(16'hBEEF);
      rd_start  = 1'b0;
      rd_stall  = 1'b0;
      rd_base   = '0;
      rd_count  = '0;

      #2;
      chk("rst_gnt", 512'({host_gnt, acc_gnt}), 512'(0));
      repeat (2) @(negedge clk);
      chk("rst_ctrl", 512'({host_gnt, acc_gnt, ub_write, ub_read,
                            rd_busy, rd_valid, rd_done}), 512'(0));
      chk("rst_addr", 512'({ub_addr_wr, ub_addr_rd}), 512'(0));
      chk("rst_data", ub_data, 512'(0));

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         host_req  = v[i].h;
         acc_req   = v[i].a;
         host_addr = v[i].ha;
         acc_addr  = v[i].aa;
         host_data = mkword(v[i].hd);
         acc_data  = mkword(v[i].ad);
         @(negedge clk);
         chk($sformatf("gnt_v%0d", i), 512'({host_gnt, acc_gnt}),
             512'({v[i].eh, v[i].ea}));
         if (v[i].eh) wr_q.push_back('{v[i].ha, mkword(v[i].hd)});
         if (v[i].ea) wr_q.push_back('{v[i].aa, mkword(v[i].ad)});
         @(posedge clk);
         #1;
      end
      host_req = 1'b0;
      acc_req  = 1'b0;
      repeat (2) @(negedge clk);
      chk("wr_q_empty", 512'(wr_q.size()), 512'(0));
      chk("wr_hold", 512'({ub_write, ub_addr_wr}), 512'({1'b0, 12'h00A}));
      chk("wr_hold_data", ub_data, mkword(16'h5A5A));

      burst(12'h100, 12'd3, 0, 0, 1'b0);
      burst(12'hFFE, 12'd3, 0, 0, 1'b0);
      burst(12'h040, 12'd0, 0, 0, 1'b0);
      burst(12'h200, 12'd3, 2, 2, 1'b0);
      burst(12'h300, 12'd4, 0, 0, 1'b1);

      @(posedge clk);
      #1;
      vcnt = 0;
      dcnt = 0;
      rd_start = 1'b1;
      rd_base  = 12'h500;
      rd_count = 12'd9;
      for (int k = 0; k < 10; k++) rd_q.push_back(12'h500 + AW'(k));
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", 512'({ub_read, rd_busy, rd_valid, rd_done,
                               ub_write}), 512'(0));
      chk("midrst_addr", 512'({ub_addr_rd, ub_addr_wr}), 512'(0));
      chk("midrst_data", ub_data, 512'(0));
      rd_q.delete();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      host_req = 1'b1;
      acc_req  = 1'b1;
      host_addr = 12'h0C0;
      host_data = mkword(16'h0C0C);
      @(negedge clk);
      chk("post_rst_prio", 512'({host_gnt, acc_gnt}), 512'(2'b10));
      wr_q.push_back('{12'h0C0, mkword(16'h0C0C)});
      @(posedge clk);
      #1;
      host_req = 1'b0;
      acc_req  = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrst_no_done", 512'({vcnt, dcnt}), 512'(0));
      chk("midrst_idle", 512'(rd_busy), 512'(0));
      chk("wr_q_final", 512'(wr_q.size()), 512'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ub_access_controller.md
Name: ub_access_controller

Overview:
- Sequences the unified buffer's single write port and single read port.
- Write side: round-robin arbitration between two word-write requesters, host DMA and accumulator drain. Each winner's request is registered onto the buffer write port.
- Read side: a burst engine streams a contiguous address range from the buffer toward the systolic array. It supports back-pressure and signals completion.

Parameters:
- ADDR_W, 12, buffer word-address width (4096 words).
- LANES, 32, 16-bit elements per buffer word.
- DATA_W, 16, element width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- host_wr_req_i  in  1  host requests a word write.
- host_wr_addr_i  in  ADDR_W  host write address.
- host_wr_data_i  in  DATA_W x LANES  host write word.
- host_wr_gnt_o  out  1  host request accepted this cycle (combinational).
- acc_wr_req_i  in  1  accumulator requests a word write.
- acc_wr_addr_i  in  ADDR_W  accumulator write address.
- acc_wr_data_i  in  DATA_W x LANES  accumulator write word.
- acc_wr_gnt_o  out  1  accumulator request accepted this cycle (combinational).
- rd_start_i  in  1  start read burst; ignored while rd_busy_o=1.
- rd_base_i  in  ADDR_W  first burst address.
- rd_count_i  in  ADDR_W  burst length minus one (1..4096 words).
- rd_stall_i  in  1  consumer back-pressure.
- rd_busy_o  out  1  burst in progress.
- rd_valid_o  out  1  buffer read data valid this cycle.
- rd_done_o  out  1  one-cycle pulse with the last valid word.
- ub_write_o  out  1  buffer write enable.
- ub_addr_wr_o  out  ADDR_W  buffer write address.
- ub_data_o  out  DATA_W x LANES  buffer write data.
- ub_read_o  out  1  buffer read enable.
- ub_addr_rd_o  out  ADDR_W  buffer read address.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All registered outputs are 0, ub_data_o included.
  - Read FSM goes to IDLE.
  - Round-robin priority goes to host.
  - Both grants are 0 while reset is asserted.
- Write arbiter:
  - Only one requester asserting: that requester is granted in the same cycle.
  - Both asserting: the priority holder is granted.
  - After any grant, priority moves to the non-granted requester.
  - No request: priority holds.
- Write port:
  - On the edge after a grant, ub_write_o=1, with ub_addr_wr_o and ub_data_o taken from the granted requester.
  - Otherwise ub_write_o=0 and address/data hold their last values.
  - Sustained throughput is one write per cycle. Two requesters both held asserted are granted alternately.
- Read FSM states: IDLE, BURST, DRAIN.
  - IDLE: on rd_start_i=1, latch base and count, go to BURST, set ub_read_o=1 and ub_addr_rd_o=rd_base_i.
  - BURST: each edge with rd_stall_i=0 issues the next address, base+k modulo 2^ADDR_W (wraps 4095→0).
  - BURST with rd_stall_i=1 at an edge: ub_read_o=0 next cycle and the address does not advance.
  - BURST exit: after issuing address k=count, go to DRAIN with ub_read_o=0.
  - DRAIN: lasts one cycle, then IDLE.
- Read data timing:
  - rd_valid_o is ub_read_o delayed one cycle, matching the buffer's one-cycle read latency.
  - The consumer must accept one in-flight word after raising rd_stall_i.
  - rd_done_o=1 in the cycle of the last rd_valid_o.
- Busy and latency:
  - rd_busy_o=1 from BURST entry through the rd_done_o cycle.
  - Unstalled burst of N words started in cycle T: ub_read_o high T+1..T+N, rd_valid_o high T+2..T+N+1, rd_done_o at T+N+1.
  - A new rd_start_i is accepted from T+N+2.
- Read and write are independent and may both be active in the same cycle. A same-address collision returns the pre-write contents; no hazard check is made.
- Reset mid-burst aborts the burst with no rd_done_o pulse.

Test Plan:
- Reset with host and accumulator requests both held → grants=0, ub_write_o=0. After release, host is granted first, then the grants alternate host/acc/host.
- Only acc requests, addr=0x010, data lane0=0x1234 → acc_wr_gnt_o=1 same cycle. Next cycle ub_write_o=1, ub_addr_wr_o=0x010, ub_data_o[0]=0x1234.
- rd_start_i, base=0x100, count=3 at cycle T:
  - ub_read_o high T+1..T+4, addresses 0x100..0x103.
  - rd_valid_o high T+2..T+5, rd_done_o at T+5.
  - busy low at T+6.
- base=0xFFE, count=3 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- rd_stall_i high for 2 cycles mid-burst → two ub_read_o gaps with the address held. The total valid count still equals 4 and rd_done_o fires once.
- rd_start_i while busy is ignored. rst_ni low mid-burst → immediate IDLE, all outputs 0, no rd_done_o.
